// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared encodings for the ALU arbiter slice
// State codes, ALU op codes and flag bit positions used by arbiter and ALU model.
package alu_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_EXEC = S_EXEC,
    ST_RESP = S_RESP
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // A zero-latency ALU still needs a one-bit counter to exist.
  function automatic int lat_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu32bit.sv
// rtl/alu32bit.sv - combinational 32-bit ALU (add/sub/and/or) with NZCV flags
// Datapath shared by the arbiter's requesters.
module ALU32bit
  import alu_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  alu_control,
  output logic [31:0] alu_result,
  output logic [3:0]  alu_flags
);

  logic [32:0] sum;

  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_flags  = '0;
    case (alu_control)
      OP_ADD: begin
        sum                = {1'b0, a} + {1'b0, b};
        alu_result         = sum[31:0];
        alu_flags[FLG_C]   = sum[32];
        alu_flags[FLG_V]   = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        sum                = {1'b0, a} + {1'b0, ~b} + 33'd1;
        alu_result         = sum[31:0];
        alu_flags[FLG_C]   = sum[32];
        alu_flags[FLG_V]   = (a[31] != b[31]) && (sum[31] != a[31]);
      end
      OP_AND:  alu_result = a & b;
      default: alu_result = a | b;
    endcase
    alu_flags[FLG_N] = alu_result[31];
    alu_flags[FLG_Z] = (alu_result == 32'd0);
  end

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational rotating-priority picker
// Searches upward from ptr (or from 0 when fixed_prio) and returns one-hot grant plus index.
module rr_grant #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           fixed_prio,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_vld
);

  int base;
  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    base    = fixed_prio ? 0 : int'(ptr);
    for (int k = 0; k < N; k++) begin
      j = (base + k) % N;
      if (!gnt_vld && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU32bit between N requesters, one op in flight
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [2*N-1:0]    req_op,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [1:0]        alu_ctrl,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int LW = lat_w(ALU_LAT);
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;
  logic [1:0]     alu_ctrl_q, alu_ctrl_d;
  logic [31:0]    alu_a_q, alu_a_d;
  logic [31:0]    alu_b_q, alu_b_d;

  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_vld;

  rr_grant #(.N(N), .IDW(IDW)) u_grant (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .fixed_prio (FIXED_PRIO),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lat_cnt_d    = lat_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (gnt_vld) begin
          alu_ctrl_d = req_op[2*gnt_idx +: 2];
          alu_a_d    = req_a[32*gnt_idx +: 32];
          alu_b_d    = req_b[32*gnt_idx +: 32];
          rsp_id_d   = gnt_idx;
          lat_cnt_d  = LW'(ALU_LAT);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_valid_d  = 1'b1;
          // Pointer moves just past the requester being served.
          if (FIXED_PRIO || rsp_id_q == IDW'(N - 1)) rr_ptr_d = '0;
          else                                      rr_ptr_d = rsp_id_q + IDW'(1);
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lat_cnt_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lat_cnt_q    <= lat_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with ALU32bit
// Expected ids under ALU_ARB_FIXED_PRIO_EN differ only in the contention scenario.
module tb_alu_arbiter;

  localparam int N       = 4;
  localparam int ALU_LAT = 1;
  localparam int IDW     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [2*N-1:0]    req_op = '0;
  logic [32*N-1:0]   req_a = '0;
  logic [32*N-1:0]   req_b = '0;
  logic [1:0]        alu_ctrl;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic              busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .ALU_LAT(ALU_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  ALU32bit u_alu (
    .a(alu_a), .b(alu_b), .alu_control(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if ({busy, rsp_valid, req_ready} !== '0) $display("FAIL reset_ctl: busy/valid/ready=%b required 0", {busy, rsp_valid, req_ready}); else passed++;
    total++; if ({rsp_id, rsp_result, rsp_flags} !== '0) $display("FAIL reset_rsp: got %h required 0", {rsp_id, rsp_result, rsp_flags}); else passed++;
    total++; if ({alu_ctrl, alu_a, alu_b} !== '0) $display("FAIL reset_alu: got %h required 0", {alu_ctrl, alu_a, alu_b}); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    int cyc;
    req_op[1:0]  = 2'b00;
    req_a[31:0]  = 32'd6;
    req_b[31:0]  = 32'd0;
    req_valid    = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b required 0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    total++; if (busy !== 1'b1 || alu_a !== 32'd6 || alu_ctrl !== 2'b00) $display("FAIL single_latch: busy=%b a=%h ctrl=%b required 1/6/00", busy, alu_a, alu_ctrl); else passed++;
    wait_rsp(cyc);
    total++; if (cyc !== ALU_LAT + 1) $display("FAIL single_latency: got %0d required %0d", cyc, ALU_LAT + 1); else passed++;
    total++; if (rsp_id !== 3'd0 || rsp_result !== 32'd6 || rsp_flags !== 4'b0000) $display("FAIL single_rsp: id=%0d res=%h flg=%b required 0/6/0000", rsp_id, rsp_result, rsp_flags); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_accept: valid=%b busy=%b required 0/0", rsp_valid, busy); else passed++;
  endtask

  task automatic test_zero_carry();
    int cyc;
    req_op[5:4]   = 2'b01;
    req_a[95:64]  = 32'd5;
    req_b[95:64]  = 32'd5;
    req_valid     = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp(cyc);
    total++; if (rsp_id !== 3'd2 || rsp_result !== 32'd0) $display("FAIL zc_rsp: id=%0d res=%h required 2/0", rsp_id, rsp_result); else passed++;
    total++; if (rsp_flags !== 4'b0110) $display("FAIL zc_flags: got %b required 0110", rsp_flags); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int cyc;
    req_op[3:2]  = 2'b00;
    req_a[63:32] = 32'h7FFF_FFFF;
    req_b[63:32] = 32'd1;
    req_valid    = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsp(cyc);
    total++; if (rsp_id !== 3'd1 || rsp_result !== 32'h8000_0000) $display("FAIL ovf_rsp: id=%0d res=%h required 1/80000000", rsp_id, rsp_result); else passed++;
    total++; if (rsp_flags !== 4'b1001) $display("FAIL ovf_flags: got %b required 1001", rsp_flags); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_contention();
    int exp_ids[5];
    int ids[5];
    int ress[5];
    int times[5];
    int seen;
    int multi;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]  = 2'b00;
      req_a[32*i +: 32] = 32'(10 + i);
      req_b[32*i +: 32] = 32'(i);
    end
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    seen  = 0;
    multi = 0;
    for (int t = 0; t < 200 && seen < 5; t++) begin
      if ($countones(req_ready) > 1) multi++;
      tick();
      if (rsp_valid) begin
        ids[seen]   = int'(rsp_id);
        ress[seen]  = int'(rsp_result);
        times[seen] = t;
        seen++;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    total++; if (seen !== 5) $display("FAIL cont_count: got %0d responses required 5", seen); else passed++;
    total++; if (multi !== 0) $display("FAIL cont_onehot: %0d cycles with multiple req_ready required 0", multi); else passed++;
    for (int k = 0; k < seen; k++) begin
      total++; if (ids[k] !== exp_ids[k]) $display("FAIL cont_id%0d: got %0d required %0d", k, ids[k], exp_ids[k]); else passed++;
      total++; if (ress[k] !== 10 + 2*exp_ids[k]) $display("FAIL cont_res%0d: got %0d required %0d", k, ress[k], 10 + 2*exp_ids[k]); else passed++;
      if (k > 0) begin
        total++; if (times[k] - times[k-1] !== ALU_LAT + 3) $display("FAIL cont_gap%0d: got %0d required %0d", k, times[k] - times[k-1], ALU_LAT + 3); else passed++;
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    do_reset();
    req_op[1:0]    = 2'b11;
    req_a[31:0]    = 32'h0000_00F0;
    req_b[31:0]    = 32'h0000_000F;
    req_op[7:6]    = 2'b10;
    req_a[127:96]  = 32'hFF00_FF00;
    req_b[127:96]  = 32'h0F0F_0F0F;
    req_valid      = 4'b0001;
    tick();
    req_valid = 4'b1000;
    wait_rsp(cyc);
    total++; if (rsp_id !== 3'd0 || rsp_result !== 32'h0000_00FF) $display("FAIL bp_rsp: id=%0d res=%h required 0/000000ff", rsp_id, rsp_result); else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== 32'h0000_00FF || rsp_flags !== 4'b0000 || req_ready !== 4'b0000) bad++;
    end
    total++; if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles required 0", bad); else passed++;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL bp_no_grant_on_accept: got %b required 0000", req_ready); else passed++;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) $display("FAIL bp_idle: valid=%b ready=%b required 0/1000", rsp_valid, req_ready); else passed++;
    tick();
    req_valid = '0;
    total++; if (alu_a !== 32'hFF00_FF00 || alu_ctrl !== 2'b10) $display("FAIL bp_grant3: a=%h ctrl=%b required ff00ff00/10", alu_a, alu_ctrl); else passed++;
    wait_rsp(cyc);
    total++; if (rsp_id !== 3'd3 || rsp_result !== 32'h0F00_0F00 || rsp_flags !== 4'b0000) $display("FAIL bp_rsp3: id=%0d res=%h flg=%b required 3/0f000f00/0000", rsp_id, rsp_result, rsp_flags); else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    req_op[3:2]  = 2'b00;
    req_a[63:32] = 32'd100;
    req_b[63:32] = 32'd23;
    req_valid    = 4'b0010;
    tick();
    req_valid = '0;
    total++; if (busy !== 1'b1 || alu_a !== 32'd100) $display("FAIL mid_exec_state: busy=%b a=%h required 1/64", busy, alu_a); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, rsp_valid, rsp_id, rsp_result, rsp_flags} !== '0) $display("FAIL mid_reset_rsp: got %h required 0", {busy, rsp_valid, rsp_id, rsp_result, rsp_flags}); else passed++;
    total++; if ({alu_ctrl, alu_a, alu_b} !== '0) $display("FAIL mid_reset_alu: got %h required 0", {alu_ctrl, alu_a, alu_b}); else passed++;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_reset_no_rsp: %0d active cycles required 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_carry();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin controller that shares one ALU32bit instance between N requesters.
- Accepts operation requests over per-requester valid/ready handshakes and registers op/A/B onto the ALU inputs.
- Waits a fixed ALU latency, captures result plus flags, and returns them with the requester ID over a single valid/ready response channel.
- Sits between client engines and the ALU32bit datapath; exactly one operation in flight.

Parameters:
- N, 4: number of requesters (2..8).
- ALU_LAT, 1: clk edges from ALU inputs stable to ALUResult/flags valid (0 = combinational ALU).
- IDW, 3: width of rsp_id; must satisfy 2**IDW >= N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; at most one bit high per cycle.
- req_op  in  2*N  ALUControl per requester; slice i = [2i+1:2i].
- req_a  in  32*N  operand A per requester; slice i = [32i+31:32i].
- req_b  in  32*N  operand B per requester, same slicing.
- alu_ctrl  out  2  to ALU32bit ALUControl.
- alu_a  out  32  to ALU32bit A.
- alu_b  out  32  to ALU32bit B.
- alu_result  in  32  from ALU32bit ALUResult.
- alu_flags  in  4  from ALU32bit {Negative, Zero, CarryOut, Overflow}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that issued the op.
- rsp_result  out  32  captured ALUResult.
- rsp_flags  out  4  captured {N, Z, C, V}.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_ctrl=0, alu_a=0, alu_b=0, busy=0, lat_cnt=0.
- Release is synchronous to clk; first grant is possible in the first cycle after release.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit searching from rr_ptr upward, wrapping modulo N.
  - req_ready[g] is combinationally high that cycle; the handshake completes on that edge.
  - On that edge, latch req_op/a/b slice g into alu_ctrl/alu_a/alu_b, latch g as rsp_id, set lat_cnt=ALU_LAT, go to EXEC.
  - If no req_valid, stay in IDLE.
- EXEC:
  - alu_* held stable; lat_cnt decrements each cycle; duration ALU_LAT+1 cycles.
  - In the cycle where lat_cnt==0, alu_result/alu_flags are sampled into rsp_result/rsp_flags on the rising edge.
  - Same edge: rsp_valid<=1, rr_ptr<=(g+1) mod N, go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - When rsp_ready is high: rsp_valid<=0, go to IDLE.
  - No grant in the same cycle as response acceptance.
  - Minimum op period is ALU_LAT+3 cycles.
- req_ready is 0 in EXEC and RESP; requests may stay asserted and are not dropped.
- A requester deasserting req_valid before its grant is legal; it is simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. Rotating pointer guarantees each of N continuous requesters is served within N ops.
- rr_ptr wraps from N-1 to 0.
- No arithmetic in this block; flags pass through unmodified.
- Reset mid-operation (EXEC or RESP): op is discarded, no response is produced, state returns to IDLE.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: grant = lowest-index asserted req_valid; rr_ptr is unused and held at 0; requester 0 can starve others.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared package alu_arb_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2;
  - ALU op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- One sub-module, rr_grant: combinational N-bit rotating priority picker. Inputs: request vector, pointer, fixed-prio select. Outputs: one-hot grant and its binary index.
- The bench instantiates alu_arbiter plus ALU32bit.

Test Plan:
- Single op: req0 op=00, A=6, B=0 -> rsp_id=0, rsp_result=6, rsp_flags=4'b0000; rsp_valid asserted ALU_LAT+1 cycles after the grant edge.
- Zero/carry: req2 op=01, A=5, B=5 -> rsp_id=2, result=0, Z=1, C=1, N=0, V=0.
- Overflow: req1 op=00, A=32'h7FFFFFFF, B=1 -> result=32'h80000000, N=1, V=1, Z=0, C=0.
- Contention: all four req_valid held high from reset, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; no requester is granted twice before the others are served; ops are ALU_LAT+3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP with req3 pending -> rsp_* stable, req_ready stays 0; req3 is granted only after acceptance, in the next IDLE cycle.
- Reset mid-EXEC: rst_n pulsed low during EXEC -> all outputs are 0 immediately and no rsp_valid appears. With ALU_ARB_FIXED_PRIO_EN, all requesting -> rsp_id is always 0.
